// File: rtl/collectible_pool_object.sv
// Pool of NUM_SLOTS grid-aligned collectibles, each cycling EMPTY -> ACTIVE -> COOLDOWN.
// Produces one registered draw request for the VGA mux and per-player take pulses.
module collectible_pool_object #(
    parameter int          NUM_SLOTS      = 4,
    parameter int          OBJECT_WIDTH_X = 32,
    parameter int          OBJECT_HEIGHT_Y = 32,
    parameter int          GRID_SHIFT     = 5,
    parameter int          MAX_GRID_X     = 19,
    parameter int          MAX_GRID_Y     = 14,
    parameter int          RESPAWN_FRAMES = 120,
    parameter logic [7:0]  OBJECT_COLOR   = 8'h5B
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 startOfFrame,
    input  logic                 spawn_req,
    input  logic [4:0]           randomX,
    input  logic [4:0]           randomY,
    input  logic                 take1,
    input  logic                 take2,
    output logic                 drawingRequest,
    output logic [7:0]           RGBout,
    output logic [10:0]          offsetX,
    output logic [10:0]          offsetY,
    output logic                 take_p1,
    output logic                 take_p2,
    output logic                 spawn_dropped,
    output logic [NUM_SLOTS-1:0] active_mask
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    logic [1:0]        state_q    [NUM_SLOTS];
    logic [1:0]        state_d    [NUM_SLOTS];
    logic [10:0]       topLeftX_q [NUM_SLOTS];
    logic [10:0]       topLeftX_d [NUM_SLOTS];
    logic [10:0]       topLeftY_q [NUM_SLOTS];
    logic [10:0]       topLeftY_d [NUM_SLOTS];
    logic [7:0]        cnt_q      [NUM_SLOTS];
    logic [7:0]        cnt_d      [NUM_SLOTS];

    logic              drawReq_q, drawReq_d;
    logic [7:0]        rgb_q, rgb_d;
    logic [10:0]       offX_q, offX_d;
    logic [10:0]       offY_q, offY_d;
    logic [SLOT_W-1:0] hitSlot_q, hitSlot_d;
    logic              takeP1_q, takeP1_d;
    logic              takeP2_q, takeP2_d;
    logic              dropped_q, dropped_d;

    logic [4:0]        gridX, gridY;
    logic [10:0]       spawnX, spawnY;
    logic [NUM_SLOTS-1:0] hit;
    logic              anyHit, anyEmpty, hitSlotActive, takeValid;
    logic [SLOT_W-1:0] winIdx, grantIdx;
    logic [10:0]       winX, winY;

    assign gridX  = (randomX > 5'(MAX_GRID_X)) ? 5'(MAX_GRID_X) : randomX;
    assign gridY  = (randomY > 5'(MAX_GRID_Y)) ? 5'(MAX_GRID_Y) : randomY;
    assign spawnX = {6'd0, gridX} << GRID_SHIFT;
    assign spawnY = {6'd0, gridY} << GRID_SHIFT;

    // Bounds widened to 12 bits so an object touching the right/bottom edge cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit[i] = (state_q[i] == ST_ACTIVE)
                  && ({1'b0, pixelX} >= {1'b0, topLeftX_q[i]})
                  && ({1'b0, pixelX} <  ({1'b0, topLeftX_q[i]} + 12'(OBJECT_WIDTH_X)))
                  && ({1'b0, pixelY} >= {1'b0, topLeftY_q[i]})
                  && ({1'b0, pixelY} <  ({1'b0, topLeftY_q[i]} + 12'(OBJECT_HEIGHT_Y)));
        end
    end

    // Scanning downward lets the lowest-indexed candidate overwrite the others.
    always_comb begin
        anyHit   = 1'b0;
        winIdx   = '0;
        winX     = '0;
        winY     = '0;
        anyEmpty = 1'b0;
        grantIdx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                anyHit = 1'b1;
                winIdx = SLOT_W'(i);
                winX   = topLeftX_q[i];
                winY   = topLeftY_q[i];
            end
            if (state_q[i] == ST_EMPTY) begin
                anyEmpty = 1'b1;
                grantIdx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        hitSlotActive = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((hitSlot_q == SLOT_W'(i)) && (state_q[i] == ST_ACTIVE)) begin
                hitSlotActive = 1'b1;
            end
        end
    end

    assign takeValid = drawReq_q && (take1 || take2) && hitSlotActive;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i]    = state_q[i];
            topLeftX_d[i] = topLeftX_q[i];
            topLeftY_d[i] = topLeftY_q[i];
            cnt_d[i]      = cnt_q[i];
            if (spawn_req && anyEmpty && (grantIdx == SLOT_W'(i))) begin
                state_d[i]    = ST_ACTIVE;
                topLeftX_d[i] = spawnX;
                topLeftY_d[i] = spawnY;
            end
            if (takeValid && (hitSlot_q == SLOT_W'(i))) begin
                state_d[i] = ST_COOLDOWN;
                cnt_d[i]   = 8'(RESPAWN_FRAMES);
            end
            if ((state_q[i] == ST_COOLDOWN) && startOfFrame) begin
                if (cnt_q[i] == 8'd1) begin
                    state_d[i] = ST_EMPTY;
                    cnt_d[i]   = 8'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] - 8'd1;
                end
            end
        end
    end

    // Player 1 has priority when both players claim the object in the same cycle.
    always_comb begin
        drawReq_d = anyHit;
        rgb_d     = anyHit ? OBJECT_COLOR : 8'hFF;
        offX_d    = anyHit ? (pixelX - winX) : 11'd0;
        offY_d    = anyHit ? (pixelY - winY) : 11'd0;
        hitSlot_d = anyHit ? winIdx : hitSlot_q;
        takeP1_d  = takeValid && take1;
        takeP2_d  = takeValid && !take1;
        dropped_d = spawn_req && !anyEmpty;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i]    <= ST_EMPTY;
                topLeftX_q[i] <= '0;
                topLeftY_q[i] <= '0;
                cnt_q[i]      <= '0;
            end
            drawReq_q <= 1'b0;
            rgb_q     <= 8'hFF;
            offX_q    <= '0;
            offY_q    <= '0;
            hitSlot_q <= '0;
            takeP1_q  <= 1'b0;
            takeP2_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i]    <= state_d[i];
                topLeftX_q[i] <= topLeftX_d[i];
                topLeftY_q[i] <= topLeftY_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
            drawReq_q <= drawReq_d;
            rgb_q     <= rgb_d;
            offX_q    <= offX_d;
            offY_q    <= offY_d;
            hitSlot_q <= hitSlot_d;
            takeP1_q  <= takeP1_d;
            takeP2_q  <= takeP2_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_mask[i] = (state_q[i] == ST_ACTIVE);
        end
    end

    assign drawingRequest = drawReq_q;
    assign RGBout         = rgb_q;
    assign offsetX        = offX_q;
    assign offsetY        = offY_q;
    assign take_p1        = takeP1_q;
    assign take_p2        = takeP2_q;
    assign spawn_dropped  = dropped_q;

endmodule

// File: tb/tb_collectible_pool_object.sv
// Bench for collectible_pool_object: a pickup-level model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_collectible_pool_object;

    localparam int NS    = 4;
    localparam int RESP  = 3;
    localparam int CELL  = 32;
    localparam int OW    = 32;
    localparam int OH    = 32;
    localparam int MAXGX = 19;
    localparam int MAXGY = 14;

    logic          clk = 1'b0;
    logic          resetN;
    logic [10:0]   pixelX, pixelY;
    logic          startOfFrame, spawn_req, take1, take2;
    logic [4:0]    randomX, randomY;
    logic          drawingRequest, take_p1, take_p2, spawn_dropped;
    logic [7:0]    RGBout;
    logic [10:0]   offsetX, offsetY;
    logic [NS-1:0] active_mask;

    int nPass   = 0;
    int nChecks = 0;
    bit cmpOn   = 1'b0;

    collectible_pool_object #(.NUM_SLOTS(NS), .RESPAWN_FRAMES(RESP)) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .spawn_req(spawn_req),
        .randomX(randomX), .randomY(randomY), .take1(take1), .take2(take2),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .offsetX(offsetX), .offsetY(offsetY), .take_p1(take_p1), .take_p2(take_p2),
        .spawn_dropped(spawn_dropped), .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    // Pickup-level model: whether each slot is on screen, frames left before it
    // may be reused, and its pixel position.
    bit     mActive [NS];
    int     mCool   [NS];
    int     mX      [NS];
    int     mY      [NS];
    bit     expDraw, expP1, expP2, expDrop;
    int     expRgb, expOffX, expOffY, expHit;
    logic [NS-1:0] expMask;
    int     takeSlot, hitIdx, spawnIdx;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NS; i++) begin
                mActive[i] = 1'b0; mCool[i] = 0; mX[i] = 0; mY[i] = 0;
            end
            expDraw = 0; expRgb = 'hFF; expOffX = 0; expOffY = 0; expHit = 0;
            expP1 = 0; expP2 = 0; expDrop = 0; expMask = '0;
        end else begin
            takeSlot = -1;
            if (expDraw && (take1 || take2) && mActive[expHit]) takeSlot = expHit;
            expP1 = (takeSlot >= 0) && take1;
            expP2 = (takeSlot >= 0) && !take1;
            hitIdx = -1;
            for (int i = 0; i < NS; i++) begin
                if (hitIdx < 0 && mActive[i] && int'(pixelX) >= mX[i] && int'(pixelX) < mX[i] + OW
                    && int'(pixelY) >= mY[i] && int'(pixelY) < mY[i] + OH) hitIdx = i;
            end
            spawnIdx = -1;
            if (spawn_req) begin
                for (int i = 0; i < NS; i++)
                    if (spawnIdx < 0 && !mActive[i] && mCool[i] == 0) spawnIdx = i;
            end
            expDrop = spawn_req && (spawnIdx < 0);
            if (hitIdx >= 0) begin
                expDraw = 1; expRgb = 'h5B; expHit = hitIdx;
                expOffX = int'(pixelX) - mX[hitIdx]; expOffY = int'(pixelY) - mY[hitIdx];
            end else begin
                expDraw = 0; expRgb = 'hFF; expOffX = 0; expOffY = 0;
            end
            if (startOfFrame)
                for (int i = 0; i < NS; i++) if (mCool[i] > 0) mCool[i] = mCool[i] - 1;
            if (takeSlot >= 0) begin
                mActive[takeSlot] = 0; mCool[takeSlot] = RESP;
            end
            if (spawnIdx >= 0) begin
                mActive[spawnIdx] = 1;
                mX[spawnIdx] = ((int'(randomX) > MAXGX) ? MAXGX : int'(randomX)) * CELL;
                mY[spawnIdx] = ((int'(randomY) > MAXGY) ? MAXGY : int'(randomY)) * CELL;
            end
            for (int i = 0; i < NS; i++) expMask[i] = mActive[i];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("drawingRequest", 32'(drawingRequest), 32'(expDraw));
            checkOutput("RGBout", 32'(RGBout), expRgb);
            checkOutput("offsetX", 32'(offsetX), expOffX);
            checkOutput("offsetY", 32'(offsetY), expOffY);
            checkOutput("take_p1", 32'(take_p1), 32'(expP1));
            checkOutput("take_p2", 32'(take_p2), 32'(expP2));
            checkOutput("spawn_dropped", 32'(spawn_dropped), 32'(expDrop));
            checkOutput("active_mask", 32'(active_mask), 32'(expMask));
        end
    end

    // Inputs change 1ns after the edge; outputs of that edge are visible by then.
    task automatic applyStimulus(input bit sr, input int rx, input int ry, input int px,
                                 input int py, input bit sof, input bit t1, input bit t2);
        spawn_req = sr; randomX = 5'(rx); randomY = 5'(ry);
        pixelX = 11'(px); pixelY = 11'(py); startOfFrame = sof; take1 = t1; take2 = t2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        resetN = 1'b0;
        idle(3);
        resetN = 1'b1;
        idle(1);
    endtask

    initial begin
        resetN = 1'b0;
        spawn_req = 0; randomX = 0; randomY = 0; pixelX = 0; pixelY = 0;
        startOfFrame = 0; take1 = 0; take2 = 0;
        @(posedge clk);
        #1;
        cmpOn = 1'b1;
        doReset();

        $display("[TB] empty frame scan");
        for (int y = 0; y < 480; y += 16)
            for (int x = 0; x < 640; x += 16) applyStimulus(0, 0, 0, x, y, (x == 0 && y == 0), 0, 0);
        checkOutput("scan_mask", 32'(active_mask), 0);
        checkOutput("scan_rgb", 32'(RGBout), 'hFF);

        $display("[TB] single spawn and hit");
        applyStimulus(1, 3, 2, 0, 0, 0, 0, 0);
        checkOutput("spawn1_mask", 32'(active_mask), 1);
        applyStimulus(0, 0, 0, 100, 70, 0, 0, 0);
        checkOutput("hit_draw", 32'(drawingRequest), 1);
        checkOutput("hit_rgb", 32'(RGBout), 'h5B);
        checkOutput("hit_offX", 32'(offsetX), 4);
        checkOutput("hit_offY", 32'(offsetY), 6);
        applyStimulus(0, 0, 0, 128, 70, 0, 0, 0);
        checkOutput("right_edge_draw", 32'(drawingRequest), 0);

        $display("[TB] clamped spawn");
        applyStimulus(1, 31, 31, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 639, 479, 0, 0, 0);
        checkOutput("clamp_draw", 32'(drawingRequest), 1);
        checkOutput("clamp_offX", 32'(offsetX), 31);
        checkOutput("clamp_offY", 32'(offsetY), 31);
        applyStimulus(0, 0, 0, 607, 479, 0, 0, 0);
        checkOutput("clamp_left_draw", 32'(drawingRequest), 0);

        $display("[TB] pool full");
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, k, 0, 0, 0, 0, 0, 0);
            checkOutput("full_dropped", 32'(spawn_dropped), (k == 4) ? 1 : 0);
        end
        checkOutput("full_mask", 32'(active_mask), 'hF);

        $display("[TB] simultaneous take");
        applyStimulus(0, 0, 0, 5, 5, 0, 0, 0);
        checkOutput("take_pre_draw", 32'(drawingRequest), 1);
        applyStimulus(0, 0, 0, 5, 5, 0, 1, 1);
        checkOutput("both_p1", 32'(take_p1), 1);
        checkOutput("both_p2", 32'(take_p2), 0);
        checkOutput("both_mask", 32'(active_mask), 'hE);
        applyStimulus(0, 0, 0, 5, 5, 0, 1, 0);
        checkOutput("repeat_p1", 32'(take_p1), 0);

        $display("[TB] cooldown and respawn");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 10, 10, 0, 0, 0, 0, 0);
        checkOutput("early_spawn_dropped", 32'(spawn_dropped), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 10, 10, 0, 0, 0, 0, 0);
        checkOutput("respawn_mask", 32'(active_mask), 'hF);
        checkOutput("respawn_dropped", 32'(spawn_dropped), 0);
        applyStimulus(0, 0, 0, 320, 320, 0, 0, 0);
        checkOutput("respawn_offX", 32'(offsetX), 0);
        checkOutput("respawn_draw", 32'(drawingRequest), 1);

        $display("[TB] expiry same cycle as spawn");
        applyStimulus(0, 0, 0, 330, 330, 0, 0, 1);
        checkOutput("p2_only", 32'(take_p2), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 5, 0, 0, 1, 0, 0);
        checkOutput("expiry_dropped", 32'(spawn_dropped), 1);
        checkOutput("expiry_mask", 32'(active_mask), 'hE);
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
        checkOutput("after_expiry_mask", 32'(active_mask), 'hF);

        $display("[TB] reset mid-cooldown");
        applyStimulus(0, 0, 0, 1, 161, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 161, 0, 1, 0);
        checkOutput("pre_reset_p1", 32'(take_p1), 1);
        applyStimulus(0, 0, 0, 1, 161, 1, 0, 0);
        resetN = 1'b0;
        #1;
        checkOutput("async_mask", 32'(active_mask), 0);
        checkOutput("async_draw", 32'(drawingRequest), 0);
        checkOutput("async_rgb", 32'(RGBout), 'hFF);
        idle(3);
        resetN = 1'b1;
        idle(4);
        checkOutput("post_reset_p1", 32'(take_p1), 0);
        checkOutput("post_reset_mask", 32'(active_mask), 0);

        $display("[TB] randomized phase");
        for (int c = 0; c < 4000; c++) begin
            int rx, ry, px, py;
            if ($urandom_range(0, 7) == 0) begin
                rx = $urandom_range(0, 31); ry = $urandom_range(0, 31);
                px = $urandom_range(0, 700); py = $urandom_range(0, 520);
            end else begin
                rx = $urandom_range(0, 4); ry = $urandom_range(0, 4);
                px = $urandom_range(0, 170); py = $urandom_range(0, 170);
            end
            if ($urandom_range(0, 499) == 0) resetN = 1'b0;
            else resetN = 1'b1;
            applyStimulus($urandom_range(0, 5) == 0, rx, ry, px, py,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end
        resetN = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/collectible_pool_object.md
Name: collectible_pool_object

Overview:
- Multi-slot successor to the single gold-square collectible. Manages NUM_SLOTS independent grid-aligned pickups, each with its own lifecycle FSM (EMPTY/ACTIVE/COOLDOWN).
- Provides one registered drawing request with colour and offsets to the VGA object mux, and per-player take pulses to the score logic.
- Spawn positions come from the shared random generator.

Parameters:
- NUM_SLOTS, 4: number of independent collectible slots (1..8).
- OBJECT_WIDTH_X, 32: object width in pixels.
- OBJECT_HEIGHT_Y, 32: object height in pixels.
- GRID_SHIFT, 5: log2 of grid cell size; topLeft = grid << GRID_SHIFT.
- MAX_GRID_X, 19: largest legal grid column; larger random values are clamped to it.
- MAX_GRID_Y, 14: largest legal grid row; larger random values are clamped to it.
- RESPAWN_FRAMES, 120: frames a slot stays in COOLDOWN after being taken (1..255).
- OBJECT_COLOR, 8'h5B: RGB332 colour of an active object.

Ports:
- clk, input, 1: system clock.
- resetN, input, 1: asynchronous, active-low reset.
- pixelX, input, 11: current VGA pixel column.
- pixelY, input, 11: current VGA pixel row.
- startOfFrame, input, 1: one-cycle pulse per frame.
- spawn_req, input, 1: one-cycle request to place a new object.
- randomX, input, 5: random grid column.
- randomY, input, 5: random grid row.
- take1, input, 1: player-1 collision with this block's drawn pixel.
- take2, input, 1: player-2 collision with this block's drawn pixel.
- drawingRequest, output, 1: registered; current pixel is inside an ACTIVE object.
- RGBout, output, 8: registered pixel colour.
- offsetX, output, 11: registered offset of the pixel from the hit object's topLeftX.
- offsetY, output, 11: registered offset of the pixel from the hit object's topLeftY.
- take_p1, output, 1: one-cycle pulse; player 1 collected an object.
- take_p2, output, 1: one-cycle pulse; player 2 collected an object.
- spawn_dropped, output, 1: one-cycle pulse; spawn_req arrived with no EMPTY slot.
- active_mask, output, NUM_SLOTS: bit i set when slot i is ACTIVE.

Behaviour:
- Reset (asynchronous, resetN=0):
  - all slots EMPTY, topLeft registers 0, cooldown counters 0;
  - drawingRequest=0, RGBout=8'hFF (transparent), offsets=0;
  - take_p1=take_p2=spawn_dropped=0, active_mask=0, hit_slot register 0.
- Reset mid-frame or mid-cooldown discards all state; no pulses are emitted on release.
- Per-slot FSM:
  - EMPTY -> ACTIVE on spawn grant. Latch topLeftX = min(randomX, MAX_GRID_X) << GRID_SHIFT and topLeftY = min(randomY, MAX_GRID_Y) << GRID_SHIFT, both 11-bit zero-extended.
  - ACTIVE -> COOLDOWN on a take directed at this slot. Load counter = RESPAWN_FRAMES.
  - COOLDOWN: counter decrements on each startOfFrame. On the startOfFrame where counter==1 the slot moves to EMPTY. It never auto-spawns.
- Spawn grant:
  - spawn_req targets the lowest-indexed slot that is EMPTY in the current cycle.
  - If none is EMPTY, pulse spawn_dropped the next cycle and change no state.
  - A slot expiring from COOLDOWN in the same cycle is not eligible until the following cycle.
- Hit test:
  - slot i hits when ACTIVE, pixelX >= topLeftX, pixelX < topLeftX+OBJECT_WIDTH_X, pixelY >= topLeftY and pixelY < topLeftY+OBJECT_HEIGHT_Y.
  - Bounds are computed at 12 bits so the right/bottom edges do not wrap.
  - Overlapping slots: the lowest index wins.
- Drawing (1-cycle latency): the cycle after the pixel is presented:
  - on a hit: drawingRequest=1, RGBout=OBJECT_COLOR, offsets = pixel − winner topLeft, hit_slot register = winner index;
  - otherwise: drawingRequest=0, RGBout=8'hFF, offsets=0.
- Take handling:
  - take1/take2 are honoured only while drawingRequest=1 and apply to the registered hit_slot.
  - That slot goes to COOLDOWN the next cycle; take_p1 or take_p2 pulses in that same cycle.
  - If take1 and take2 arrive together, player 1 wins: only take_p1 pulses.
  - Takes while drawingRequest=0, or against a slot already left ACTIVE, are ignored, so exactly one pulse is produced per object.
- Simultaneous events: a spawn into slot j and a take of slot k≠j in the same cycle are both performed.
- active_mask is registered and reflects FSM state directly.

Test Plan:
- Reset, then scan a full frame -> drawingRequest never 1, RGBout=8'hFF throughout, active_mask=4'b0000.
- spawn_req with randomX=3, randomY=2, then pixel (100,70) -> next cycle drawingRequest=1, RGBout=8'h5B, offsetX=4, offsetY=6, active_mask=4'b0001. Pixel (128,70) gives drawingRequest=0.
- randomX=31, randomY=31 spawn -> object at (608,448). Pixel (639,479) hits with offsets (31,31).
- Five spawn_req pulses with 4 slots -> active_mask=4'b1111, and spawn_dropped pulses exactly once, on the fifth request.
- While drawing slot 0, assert take1 and take2 together -> take_p1 pulses once, take_p2 stays 0, active_mask bit0 clears. A repeat take1 is ignored.
- With RESPAWN_FRAMES=3, take slot 0 and then give 3 startOfFrame pulses -> slot becomes EMPTY after the 3rd pulse. The next spawn_req lands in slot 0. Asserting resetN=0 mid-cooldown clears everything immediately.
